// File: rtl/svga_vdg_pixel_decoder_pkg.sv
// Shared constants for the MC6847-style pixel decoder: fetch edge numbers,
// colour indices, attribute record and the 12-bit RGB colour table.
package svga_vdg_pixel_decoder_pkg;

  localparam int FONT_ROWS  = 12;
  localparam int DECODE_DLY = 7;

  // Phase (subchar_pixel value) whose closing edge performs each pipeline step.
  localparam logic [3:0] EDGE_FETCH = 4'd0;
  localparam logic [3:0] EDGE_CODE  = 4'd2;
  localparam logic [3:0] EDGE_FONT  = 4'd3;
  // Dot 0 reaches rgb two clocks after the load: one clock in the shifter, one in the output register.
  localparam logic [3:0] EDGE_LOAD  = 4'(DECODE_DLY - 2);

  // Semigraphics cells split into an upper and a lower half of font rows.
  localparam logic [3:0] SEMI_SPLIT_ROW = 4'(FONT_ROWS / 2);

  localparam logic [3:0] COL_GREEN     = 4'd0;
  localparam logic [3:0] COL_YELLOW    = 4'd1;
  localparam logic [3:0] COL_BLUE      = 4'd2;
  localparam logic [3:0] COL_RED       = 4'd3;
  localparam logic [3:0] COL_BUFF      = 4'd4;
  localparam logic [3:0] COL_CYAN      = 4'd5;
  localparam logic [3:0] COL_MAGENTA   = 4'd6;
  localparam logic [3:0] COL_ORANGE    = 4'd7;
  localparam logic [3:0] COL_BLACK     = 4'd8;
  localparam logic [3:0] COL_DK_GREEN  = 4'd9;
  localparam logic [3:0] COL_DK_ORANGE = 4'd10;

  typedef enum logic {
    MODE_TEXT = 1'b0,
    MODE_GFX  = 1'b1
  } vdg_mode_t;

  // Everything needed to colour the dots currently in the shifter.
  typedef struct packed {
    vdg_mode_t  mode;
    logic       css;
    logic [3:0] fg;
    logic [3:0] bg;
  } vdg_attr_t;

  function automatic logic [11:0] colour_rgb(input logic [3:0] idx);
    logic [11:0] val;
    case (idx)
      COL_GREEN:     val = 12'h0F0;
      COL_YELLOW:    val = 12'hFF0;
      COL_BLUE:      val = 12'h00F;
      COL_RED:       val = 12'hF00;
      COL_BUFF:      val = 12'hFFF;
      COL_CYAN:      val = 12'h0FF;
      COL_MAGENTA:   val = 12'hF0F;
      COL_ORANGE:    val = 12'hF80;
      COL_BLACK:     val = 12'h000;
      COL_DK_GREEN:  val = 12'h040;
      COL_DK_ORANGE: val = 12'h420;
      default:       val = 12'h000;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/svga_vdg_palette.sv
// Combinational colour lookup: 4-bit colour index to {r,g,b} nibbles.
module svga_vdg_palette
  import svga_vdg_pixel_decoder_pkg::*;
(
  input  logic [3:0]  index,
  output logic [11:0] rgb
);

  assign rgb = colour_rgb(index);

endmodule

// File: rtl/svga_vdg_pixel_decoder.sv
// Character/graphics fetch pipeline and dot shifter producing doubled
// MC6847-style pixels as registered 12-bit RGB.
module svga_vdg_pixel_decoder
  import svga_vdg_pixel_decoder_pkg::*;
(
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        blank,
  input  logic        show_border,
  input  logic [3:0]  subchar_pixel,
  input  logic [4:0]  subchar_line,
  input  logic [6:0]  char_column,
  input  logic [6:0]  char_line,
  input  logic [8:0]  graph_pixel,
  input  logic [9:0]  graph_line_3x,
  input  logic        ag,
  input  logic        css,
  output logic [10:0] vram_addr,
  input  logic [7:0]  vram_data,
  output logic [9:0]  font_addr,
  input  logic [7:0]  font_data,
  output logic [11:0] rgb
);

  logic        ag_q;
  logic        css_q;
  logic [7:0]  code;
  logic [7:0]  shift_q;
  vdg_attr_t   attr_q;
  logic [10:0] fetch_addr;
  logic [7:0]  load_dots;
  vdg_attr_t   load_attr;
  logic [1:0]  quad;
  logic        shift_en;
  logic [3:0]  dot_index;
  logic [3:0]  border_index;
  logic [3:0]  pal_index;
  logic [11:0] pal_rgb;
  logic        unused_inputs;

  assign unused_inputs = ^{char_column[6:5], char_line[6:4], graph_pixel[3:0],
                           graph_line_3x[9], graph_line_3x[2:0], subchar_line[0]};

  assign fetch_addr = ag ? {graph_line_3x[8:3], graph_pixel[8:4]}
                         : {2'b00, char_line[3:0], char_column[4:0]};

  // Fetch pipeline; mode copies are taken at the cell's fetch edge so a
  // mode change never splits a cell.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      vram_addr <= '0;
      font_addr <= '0;
      code      <= '0;
      ag_q      <= 1'b0;
      css_q     <= 1'b0;
    end else begin
      if (subchar_pixel == EDGE_FETCH) begin
        vram_addr <= fetch_addr;
        ag_q      <= ag;
        css_q     <= css;
      end
      if (subchar_pixel == EDGE_CODE) begin
        code <= vram_data;
      end
      if (subchar_pixel == EDGE_FONT) begin
        font_addr <= {code[5:0], subchar_line[4:1]};
      end
    end
  end

  // The font row latched into font_addr also selects the semigraphics half.
  assign quad = (font_addr[3:0] < SEMI_SPLIT_ROW) ? code[3:2] : code[1:0];

  always_comb begin
    load_dots      = '0;
    load_attr.mode = MODE_TEXT;
    load_attr.css  = css_q;
    load_attr.fg   = COL_BLACK;
    load_attr.bg   = COL_BLACK;
    if (ag_q) begin
      load_dots      = code;
      load_attr.mode = MODE_GFX;
    end else if (code[7]) begin
      load_dots    = {{4{quad[1]}}, {4{quad[0]}}};
      load_attr.fg = {1'b0, code[6:4]};
    end else begin
      load_dots    = font_data ^ {8{code[6]}};
      load_attr.fg = css_q ? COL_ORANGE : COL_GREEN;
      load_attr.bg = css_q ? COL_DK_ORANGE : COL_DK_GREEN;
    end
  end

  // Text dots last 2 clocks (odd phases), graphics pixels 4 clocks (phases 1,5,9,13).
  assign shift_en = (attr_q.mode == MODE_GFX) ? (subchar_pixel[1:0] == 2'b01)
                                              : subchar_pixel[0];

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      shift_q <= '0;
      attr_q  <= '0;
    end else if (subchar_pixel == EDGE_LOAD) begin
      shift_q <= load_dots;
      attr_q  <= load_attr;
    end else if (shift_en) begin
      if (attr_q.mode == MODE_GFX) begin
        shift_q <= {shift_q[5:0], 2'b00};
      end else begin
        shift_q <= {shift_q[6:0], 1'b0};
      end
    end
  end

  assign dot_index    = (attr_q.mode == MODE_GFX) ? {1'b0, attr_q.css, shift_q[7:6]}
                                                  : (shift_q[7] ? attr_q.fg : attr_q.bg);
  assign border_index = ag_q ? (css_q ? COL_BUFF : COL_GREEN) : COL_BLACK;
  assign pal_index    = show_border ? border_index : dot_index;

  svga_vdg_palette u_palette (
    .index (pal_index),
    .rgb   (pal_rgb)
  );

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      rgb <= '0;
    end else begin
      rgb <= blank ? 12'h000 : pal_rgb;
    end
  end

endmodule
